// File: rtl/shift_unit_ctrl.sv
// Sequencing front-end for the 16-bit barrel shifter: drives the shifter,
// builds rotates from two passes and registers result plus Z/N/C flags.
`timescale 1ns/1ps
module shift_unit_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_data,
  input  logic [4:0]  in_amt,
  input  logic [3:0]  in_tag,
  output logic [15:0] sh_in,
  output logic [4:0]  sh_amt,
  output logic        sh_cont,
  output logic        sh_sign,
  input  logic [15:0] sh_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_tag,
  output logic        out_z,
  output logic        out_n,
  output logic        out_c
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned TW = 4;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {IDLE, P1, P2} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_q;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  temp_q;
  logic [AW-1:0]  amt_q;
  logic [TW-1:0]  tag_q;
  logic [3:0]     r;
  logic           is_rot, rot_nz, accept;
  logic           cap, cap_temp, carry;
  logic [DW-1:0]  res;

  // Rotates work modulo 16; a zero residue collapses to a single pass-through
  assign r      = amt_q[3:0];
  assign is_rot = (op_q == OP_ROL) || (op_q == OP_ROR);
  assign rot_nz = is_rot && (r != 4'd0);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = P1;
      P1:      state_nxt = rot_nz ? P2 : IDLE;
      P2:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifter drive, result selection and carry for the current pass
  always_comb begin
    in_ready = 1'b0;
    sh_in    = '0;
    sh_amt   = '0;
    sh_cont  = 1'b0;
    sh_sign  = 1'b0;
    cap      = 1'b0;
    cap_temp = 1'b0;
    res      = sh_out;
    carry    = 1'b0;
    unique case (state)
      IDLE: in_ready = !out_valid || out_ready;
      P1: begin
        sh_in = data_q;
        unique case (op_q)
          OP_SLL: begin
            sh_amt = amt_q;
            carry  = (amt_q != 5'd0 && amt_q <= 5'd16) ? data_q[4'(5'd16 - amt_q)] : 1'b0;
          end
          OP_SRL: begin
            sh_amt  = amt_q;
            sh_cont = 1'b1;
            carry   = (amt_q != 5'd0 && amt_q <= 5'd16) ? data_q[4'(amt_q - 5'd1)] : 1'b0;
          end
          OP_SRA: begin
            sh_amt  = amt_q;
            sh_cont = 1'b1;
            sh_sign = 1'b1;
            if (amt_q == 5'd0)       carry = 1'b0;
            else if (amt_q > 5'd16)  carry = data_q[15];
            else                     carry = data_q[4'(amt_q - 5'd1)];
          end
          OP_ROL, OP_ROR: begin
            sh_amt  = {1'b0, r};
            sh_cont = (op_q == OP_ROR) && rot_nz;
          end
          default: sh_amt = '0;
        endcase
        cap      = !rot_nz;
        cap_temp = rot_nz;
      end
      P2: begin
        sh_in   = data_q;
        sh_amt  = 5'd16 - {1'b0, r};
        sh_cont = (op_q == OP_ROL);
        res     = temp_q | sh_out;
        carry   = (op_q == OP_ROL) ? res[0] : res[15];
        cap     = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      data_q    <= '0;
      amt_q     <= '0;
      tag_q     <= '0;
      temp_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_z     <= 1'b0;
      out_n     <= 1'b0;
      out_c     <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= in_op;
        data_q <= in_data;
        amt_q  <= in_amt;
        tag_q  <= in_tag;
      end
      if (cap_temp) temp_q <= sh_out;
      // A capture only happens after an accept, which required the output to drain
      if (cap) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_tag   <= tag_q;
        out_z     <= (res == '0);
        out_n     <= res[15];
        out_c     <= carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_ctrl.sv
// Randomized scoreboard bench for shift_unit_ctrl with a behavioural shifter
// and an arithmetic reference model.
`timescale 1ns/1ps
module tb_shift_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [15:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [3:0]  in_tag = '0;
  logic [15:0] sh_in;
  logic [4:0]  sh_amt;
  logic        sh_cont, sh_sign;
  logic [15:0] sh_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_z, out_n, out_c;

  shift_unit_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_amt(in_amt), .in_tag(in_tag),
    .sh_in(sh_in), .sh_amt(sh_amt), .sh_cont(sh_cont), .sh_sign(sh_sign),
    .sh_out(sh_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_z(out_z), .out_n(out_n), .out_c(out_c)
  );

  always #5 clk = ~clk;

  // Behavioural barrel shifter
  always_comb begin
    if (!sh_cont)     sh_out = (sh_amt >= 5'd16) ? 16'h0 : 16'(sh_in << sh_amt);
    else if (sh_sign) sh_out = (sh_amt >= 5'd16) ? {16{sh_in[15]}} : 16'($signed(sh_in) >>> sh_amt);
    else              sh_out = (sh_amt >= 5'd16) ? 16'h0 : (sh_in >> sh_amt);
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
    logic        z, n, c;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0, pushed = 0, drained = 0, cyc = 0;
  bit   rdy_mode = 1'b0;
  logic rdy_manual = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_manual;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: shifts via wide arithmetic, rotates via a doubled word
  function automatic void model(input logic [2:0] op, input logic [15:0] d, input logic [4:0] a,
                                output logic [15:0] res, output logic c, output int lat);
    logic [32:0]        w;
    logic signed [31:0] s;
    logic [31:0]        dd;
    int                 r;
    r   = int'(a) % 16;
    dd  = {d, d};
    lat = 1;
    c   = 1'b0;
    res = d;
    case (op)
      3'd0: begin w = {17'b0, d} << a;       res = w[15:0];  c = w[16]; end
      3'd1: begin w = {1'b0, d, 16'b0} >> a; res = w[31:16]; c = w[15]; end
      3'd2: begin s = $signed({d, 16'b0}) >>> a; res = s[31:16]; c = s[15]; end
      3'd3: if (r != 0) begin dd = dd << r; res = dd[31:16]; c = res[0];  lat = 2; end
      3'd4: if (r != 0) begin dd = dd >> r; res = dd[15:0];  c = res[15]; lat = 2; end
      default: ;
    endcase
  endfunction

  // Monitor: a rising out_valid is a new result; held results must stay stable
  logic        prev_valid = 1'b0;
  logic [15:0] held_d;
  logic [3:0]  held_t;
  logic [2:0]  held_f;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_tag", 32'(out_tag), 32'(e.t));
          chk("out_z", 32'(out_z), 32'(e.z));
          chk("out_n", 32'(out_n), 32'(e.n));
          chk("out_c", 32'(out_c), 32'(e.c));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
        held_d = out_data;
        held_t = out_tag;
        held_f = {out_z, out_n, out_c};
      end else if (out_valid) begin
        chk("hold_stable", {9'd0, out_tag, out_z, out_n, out_c, out_data},
            {9'd0, held_t, held_f, held_d});
      end
      if (out_valid && out_ready) drained++;
      prev_valid = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [4:0] a,
                      input logic [3:0] t, input bit push);
    exp_t e;
    logic [15:0] res;
    logic c;
    int lat, n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = t;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push && n <= 200) begin
      model(op, d, a, res, c, lat);
      e.d = res; e.t = t; e.z = (res == 16'h0); e.n = res[15]; e.c = c;
      e.acc = cyc; e.lat = lat;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr, n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sh", {10'd0, sh_in, sh_amt, sh_cont, sh_sign}, 32'd0);
    chk("rst_out", {9'd0, out_tag, out_z, out_n, out_c, out_data}, 32'd0);
    @(posedge clk);
    #1;

    // Directed cases
    send(3'd0, 16'h8001, 5'd1,  4'd1, 1'b1);
    send(3'd2, 16'h8000, 5'd4,  4'd2, 1'b1);
    send(3'd2, 16'h8000, 5'd20, 4'd3, 1'b1);
    send(3'd1, 16'h00F0, 5'd20, 4'd4, 1'b1);
    send(3'd5, 16'hABCD, 5'd7,  4'd5, 1'b1);
    send(3'd3, 16'h1234, 5'd4,  4'd6, 1'b1);
    send(3'd4, 16'h0001, 5'd17, 4'd7, 1'b1);
    send(3'd3, 16'h5A5A, 5'd16, 4'd8, 1'b1);
    send(3'd4, 16'hBEEF, 5'd0,  4'd9, 1'b1);
    send(3'd0, 16'h1234, 5'd16, 4'd10, 1'b1);
    wait_empty();

    // Backpressure, then drain and accept on the same edge
    rdy_manual = 1'b0;
    send(3'd0, 16'h00FF, 5'd8, 4'd11, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    dr = drained;
    send(3'd1, 16'hF00F, 5'd4, 4'd12, 1'b1);
    chk("same_edge_drain", 32'(drained), 32'(dr + 1));
    chk("same_edge_cleared", 32'(out_valid), 32'd0);
    wait_empty();

    // Reset in the second pass of a rotate
    send(3'd4, 16'h0001, 5'd17, 4'd13, 1'b0);
    @(negedge clk);
    chk("ror_p1_drive", {10'd0, sh_in, sh_amt, sh_cont, sh_sign}, {10'd0, 16'h0001, 5'd1, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ror_p2_drive", {10'd0, sh_in, sh_amt, sh_cont, sh_sign}, {10'd0, 16'h0001, 5'd15, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sh", {10'd0, sh_in, sh_amt, sh_cont, sh_sign}, 32'd0);
    @(posedge clk);
    #1;
    dr = drained;
    send(3'd0, 16'h0003, 5'd2, 4'd14, 1'b1);
    wait_empty();
    chk("post_rst_drained", 32'(drained - dr), 32'd1);

    // Randomized traffic with random backpressure
    dr = drained;
    n  = pushed;
    rdy_mode = 1'b1;
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(3'($urandom), 16'($urandom), 5'($urandom), 4'($urandom), 1'b1);
    end
    rdy_mode = 1'b0;
    rdy_manual = 1'b1;
    wait_empty();
    chk("rand_drained", 32'(drained - dr), 32'(pushed - n));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
